// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter and the I/D cache controllers.
// Block geometry, memory latency and the 2-bit arbiter state encodings live here.
package mem_arbiter_pkg;

  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 16;
  localparam int WORDS          = 8;
  localparam int MEM_LAT        = 4;
  localparam int IDX_W          = $clog2(WORDS);
  localparam int CNT_W          = IDX_W + 1;
  localparam int BLOCK_OFFSET_W = $clog2(2 * WORDS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_I_FILL  = 2'd1;
  localparam logic [1:0] ST_D_FILL  = 2'd2;
  localparam logic [1:0] ST_D_WRITE = 2'd3;

  // A block is 2*WORDS bytes, so the base just clears the byte offset within the block.
  function automatic logic [ADDR_W-1:0] blockBase(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_seq.sv
// Block-fill sequencer: issues WORDS in-order reads from the latched block base and
// counts returning words so the arbiter knows when the last one lands.
module mem_fill_seq
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_active,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_issue_en,
  output logic [ADDR_W-1:0] o_issue_addr,
  output logic [IDX_W-1:0]  o_recv_idx,
  output logic              o_last
);

  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_recv_cnt;
  logic [ADDR_W-1:0] r_base;
  logic              w_issue_en;

  // Counters restart on every grant; issue_cnt stops at WORDS instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_base      <= '0;
    end else if (i_start) begin
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_base      <= blockBase(i_addr);
    end else if (i_active) begin
      if (w_issue_en) r_issue_cnt <= r_issue_cnt + 1'b1;
      if (i_valid)    r_recv_cnt  <= r_recv_cnt + 1'b1;
    end
  end

  assign w_issue_en   = i_active && (r_issue_cnt < CNT_W'(WORDS));
  assign o_issue_en   = w_issue_en;
  assign o_issue_addr = r_base + {{(ADDR_W-CNT_W-1){1'b0}}, r_issue_cnt, 1'b0};
  assign o_recv_idx   = r_recv_cnt[IDX_W-1:0];
  assign o_last       = i_active && i_valid && (r_recv_cnt == CNT_W'(WORDS-1));

  // Memory answers strictly in order, so data can never outrun the reads already issued.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (i_active && i_valid) |-> (r_recv_cnt < r_issue_cnt));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single pipelined memory between I-cache fills and D-cache fills/stores,
// alternating grants on contention and always running a granted transaction to completion.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_busy,
  output logic              d_busy,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_done,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid
);

  logic [1:0]        r_state;
  logic              r_last_d;
  logic              w_idle;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_start;
  logic              w_fill;
  logic              w_issue_en;
  logic              w_last;
  logic [ADDR_W-1:0] w_start_addr;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [IDX_W-1:0]  w_recv_idx;

  // On contention the side that did not win last time gets the grant.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_grant_d    = w_idle && d_req && (!i_req || !r_last_d);
  assign w_grant_i    = w_idle && i_req && !w_grant_d;
  assign w_start      = w_grant_i || (w_grant_d && !d_we);
  assign w_start_addr = w_grant_d ? d_addr : i_addr;
  assign w_fill       = (r_state == ST_I_FILL) || (r_state == ST_D_FILL);

  mem_fill_seq u_fill_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_start),
    .i_active     (w_fill),
    .i_valid      (mem_data_valid),
    .i_addr       (w_start_addr),
    .o_issue_en   (w_issue_en),
    .o_issue_addr (w_issue_addr),
    .o_recv_idx   (w_recv_idx),
    .o_last       (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_last_d <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state  <= d_we ? ST_D_WRITE : ST_D_FILL;
            r_last_d <= 1'b1;
          end else if (w_grant_i) begin
            r_state  <= ST_I_FILL;
            r_last_d <= 1'b0;
          end
        end
        ST_I_FILL, ST_D_FILL: if (w_last) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stores complete in their single cycle; fills finish with the last returned word.
  always_comb begin
    i_busy    = (r_state == ST_I_FILL);
    d_busy    = (r_state == ST_D_FILL) || (r_state == ST_D_WRITE);
    fill_we   = w_fill && mem_data_valid;
    fill_idx  = w_fill ? w_recv_idx : '0;
    fill_data = (w_fill && mem_data_valid) ? mem_rdata : '0;
    i_done    = (r_state == ST_I_FILL) && w_last;
    d_done    = ((r_state == ST_D_FILL) && w_last) || (r_state == ST_D_WRITE);
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == ST_D_WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_issue_en) begin
      mem_en   = 1'b1;
      mem_addr = w_issue_addr;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus hand-written
// sequences for contention, reset mid-fill and request drop.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic        iReq;
    logic        dReq;
    logic        dWe;
    logic [15:0] iAddr;
    logic [15:0] dAddr;
    logic [15:0] dWdata;
    int          dropAt;
    logic        expD;
    logic        expWrite;
    logic [15:0] expBase;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iReq = 1'b0, dReq = 1'b0, dWe = 1'b0;
  logic [15:0] iAddr = '0, dAddr = '0, dWdata = '0;
  logic        iBusy, dBusy, fillWe, iDone, dDone, memEn, memWr, memDataValid;
  logic [2:0]  fillIdx;
  logic [15:0] fillData, memAddr, memWdata, memRdata;

  int assertCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(iReq), .i_addr(iAddr),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .i_busy(iBusy), .d_busy(dBusy),
    .fill_we(fillWe), .fill_idx(fillIdx), .fill_data(fillData),
    .i_done(iDone), .d_done(dDone),
    .mem_en(memEn), .mem_wr(memWr), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .mem_data_valid(memDataValid)
  );

  // Pipelined memory: read data is the address XOR a pattern, returned MEM_LAT cycles later.
  logic [MEM_LAT-1:0] pipeV;
  logic [15:0]        pipeD [MEM_LAT];
  always @(posedge clk) begin
    if (!rst_n) begin
      pipeV <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipeD[i] <= '0;
    end else begin
      pipeV    <= {pipeV[MEM_LAT-2:0], memEn && !memWr};
      pipeD[0] <= memAddr ^ 16'h5A5A;
      for (int i = 1; i < MEM_LAT; i++) pipeD[i] <= pipeD[i-1];
    end
  end
  assign memDataValid = pipeV[MEM_LAT-1];
  assign memRdata     = pipeD[MEM_LAT-1];

  task automatic checkOutput(input string tag, input string field,
                             input logic [31:0] act, input logic [31:0] expVal);
    assertCount++;
    if (act !== expVal) begin
      failCount++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", tag, field, act, expVal);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, "i_busy", 32'(iBusy), 0);
    checkOutput(tag, "d_busy", 32'(dBusy), 0);
    checkOutput(tag, "fill_we", 32'(fillWe), 0);
    checkOutput(tag, "fill_idx", 32'(fillIdx), 0);
    checkOutput(tag, "fill_data", 32'(fillData), 0);
    checkOutput(tag, "i_done", 32'(iDone), 0);
    checkOutput(tag, "d_done", 32'(dDone), 0);
    checkOutput(tag, "mem_en", 32'(memEn), 0);
    checkOutput(tag, "mem_wr", 32'(memWr), 0);
    checkOutput(tag, "mem_addr", 32'(memAddr), 0);
    checkOutput(tag, "mem_wdata", 32'(memWdata), 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    iReq = 1'b0;
    dReq = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    iReq   = v.iReq;
    iAddr  = v.iAddr;
    dReq   = v.dReq;
    dWe    = v.dWe;
    dAddr  = v.dAddr;
    dWdata = v.dWdata;
  endtask

  // Called at a negedge with the arbiter idle; k counts cycles from the first busy cycle.
  task automatic runTxn(input int id, input vec_t v);
    int    lastK;
    string tag;
    lastK = v.expWrite ? 0 : 11;
    applyStimulus(v);
    for (int k = 0; k <= lastK + 1; k++) begin
      @(negedge clk);
      tag = $sformatf("vec%0d.k%0d", id, k);
      if (k > lastK) begin
        checkOutput(tag, "i_busy", 32'(iBusy), 0);
        checkOutput(tag, "d_busy", 32'(dBusy), 0);
        checkOutput(tag, "mem_en", 32'(memEn), 0);
        checkOutput(tag, "fill_we", 32'(fillWe), 0);
        checkOutput(tag, "i_done", 32'(iDone), 0);
        checkOutput(tag, "d_done", 32'(dDone), 0);
      end else if (v.expWrite) begin
        checkOutput(tag, "d_busy", 32'(dBusy), 1);
        checkOutput(tag, "i_busy", 32'(iBusy), 0);
        checkOutput(tag, "mem_en", 32'(memEn), 1);
        checkOutput(tag, "mem_wr", 32'(memWr), 1);
        checkOutput(tag, "mem_addr", 32'(memAddr), 32'(v.dAddr));
        checkOutput(tag, "mem_wdata", 32'(memWdata), 32'(v.dWdata));
        checkOutput(tag, "d_done", 32'(dDone), 1);
        checkOutput(tag, "i_done", 32'(iDone), 0);
        checkOutput(tag, "fill_we", 32'(fillWe), 0);
      end else begin
        checkOutput(tag, "i_busy", 32'(iBusy), 32'(!v.expD));
        checkOutput(tag, "d_busy", 32'(dBusy), 32'(v.expD));
        checkOutput(tag, "mem_en", 32'(memEn), 32'(k < 8));
        if (k < 8) begin
          checkOutput(tag, "mem_wr", 32'(memWr), 0);
          checkOutput(tag, "mem_addr", 32'(memAddr), 32'(16'(v.expBase + 16'(2 * k))));
        end
        checkOutput(tag, "fill_we", 32'(fillWe), 32'(k >= 4));
        if (k >= 4) begin
          checkOutput(tag, "fill_idx", 32'(fillIdx), 32'(k - 4));
          checkOutput(tag, "fill_data", 32'(fillData),
                      32'(16'(v.expBase + 16'(2 * (k - 4))) ^ 16'h5A5A));
        end
        checkOutput(tag, "i_done", 32'(iDone), 32'(!v.expD && k == 11));
        checkOutput(tag, "d_done", 32'(dDone), 32'(v.expD && k == 11));
      end
      if (k == v.dropAt || k == lastK) begin
        iReq = 1'b0;
        dReq = 1'b0;
      end
    end
  endtask

  vec_t vecs [6];
  logic expSide [4];
  int   expCyc [4];

  initial begin
    int          doneCnt;
    int          rxCnt;
    logic [15:0] base;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0046, 16'h7777, 16'h0000, -1, 1'b0, 1'b0, 16'h0040};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h5555, 16'h1234, 16'hBEEF, -1, 1'b1, 1'b1, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h3333, 16'h2A1F, 16'h1111, -1, 1'b1, 1'b0, 16'h2A10};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, -1, 1'b0, 1'b0, 16'hFFF0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h00C7, 16'h0000, 16'h0000,  2, 1'b0, 1'b0, 16'h00C0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h8001, -1, 1'b1, 1'b1, 16'h0000};
    expSide = '{1'b1, 1'b0, 1'b1, 1'b0};
    expCyc  = '{11, 24, 37, 50};

    @(negedge clk);
    doReset();
    checkAllZero("reset");

    for (int i = 0; i < 6; i++) runTxn(i, vecs[i]);

    // Simultaneous fill requests held continuously: D first after reset, then alternating.
    doReset();
    iReq = 1'b1;
    iAddr = 16'h0100;
    dReq = 1'b1;
    dWe = 1'b0;
    dAddr = 16'h0208;
    doneCnt = 0;
    rxCnt = 0;
    for (int k = 0; k < 56; k++) begin
      @(negedge clk);
      checkOutput($sformatf("arb.k%0d", k), "one_busy", 32'(iBusy && dBusy), 0);
      if (fillWe) begin
        base = (doneCnt < 4 && expSide[doneCnt]) ? 16'h0200 : 16'h0100;
        checkOutput($sformatf("arb.k%0d", k), "fill_idx", 32'(fillIdx), 32'(rxCnt));
        checkOutput($sformatf("arb.k%0d", k), "fill_data", 32'(fillData),
                    32'(16'(base + 16'(2 * rxCnt)) ^ 16'h5A5A));
        rxCnt++;
      end
      if (iDone || dDone) begin
        if (doneCnt < 4) begin
          checkOutput($sformatf("arb.done%0d", doneCnt), "d_done", 32'(dDone), 32'(expSide[doneCnt]));
          checkOutput($sformatf("arb.done%0d", doneCnt), "i_done", 32'(iDone), 32'(!expSide[doneCnt]));
          checkOutput($sformatf("arb.done%0d", doneCnt), "cycle", 32'(k), 32'(expCyc[doneCnt]));
        end else begin
          checkOutput($sformatf("arb.k%0d", k), "extra_done", 1, 0);
        end
        doneCnt++;
        rxCnt = 0;
        if (doneCnt == 4) begin
          iReq = 1'b0;
          dReq = 1'b0;
        end
      end
    end
    checkOutput("arb", "done_count", 32'(doneCnt), 4);
    iReq = 1'b0;
    dReq = 1'b0;

    // Reset asserted during cycle T+5 of an I fill.
    iReq = 1'b1;
    iAddr = 16'h0300;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rstMid.k%0d", k), "i_busy", 32'(iBusy), 1);
    end
    rst_n = 1'b0;
    iReq = 1'b0;
    @(negedge clk);
    checkAllZero("rstMid.k6");
    rst_n = 1'b1;
    for (int k = 7; k < 20; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rstMid.k%0d", k), "i_done", 32'(iDone), 0);
      checkOutput($sformatf("rstMid.k%0d", k), "i_busy", 32'(iBusy), 0);
      checkOutput($sformatf("rstMid.k%0d", k), "fill_we", 32'(fillWe), 0);
    end
    runTxn(10, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
